// File: rtl/pc_fetch_control_if.sv
// Fetch-side bus bundle: instruction-memory req/ack port and the decode valid/ready slot.
// The fetch controller is the master of both halves.
interface pc_fetch_control_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/pc_fetch_control.sv
// Fetch sequencer closing the PC loop with an external program_counter register:
// fetches at pc_in, presents the word to decode, and computes the next PC.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | one cycle after reset; drives RESET_PC into the PC register
// FETCH   | issuing fetches whenever the output slot is free
// HALTED  | no new fetches; slot drains, branches still redirect the PC
module pc_fetch_control #(
    parameter int              ADDR_W   = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    pc_fetch_control_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    state_t             state_q, state_d;
    logic               pending_q;
    logic               slot_free;
    logic               fetch_req;
    logic               load;
    logic               redirect;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_data_q;
    logic [ADDR_W-1:0]  instr_pc_q;

    always_comb begin
        state_d   = state_q;
        fetch_req = 1'b0;
        redirect  = 1'b0;
        pc_next   = pc_in;
        slot_free = !instr_valid_q || bus.instr_ready;
        case (state_q)
            S_IDLE: begin
                pc_next = RESET_PC;
                state_d = halt ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                redirect = branch_valid;
                // Under halt only a request already outstanding is kept alive until acked.
                fetch_req = slot_free && !branch_valid && (!halt || pending_q);
                if (branch_valid)
                    pc_next = branch_target;
                else if (fetch_req && bus.imem_ack)
                    pc_next = pc_in + ADDR_W'(1);
                if (halt && !(fetch_req && !bus.imem_ack))
                    state_d = S_HALTED;
            end
            S_HALTED: begin
                redirect = branch_valid;
                if (branch_valid)
                    pc_next = branch_target;
                if (!halt)
                    state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            fetch_req = 1'b0;
            pc_next   = RESET_PC;
        end
        load = fetch_req && bus.imem_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= fetch_req && !bus.imem_ack;
            if (load) begin
                instr_valid_q <= 1'b1;
                instr_data_q  <= bus.imem_rdata;
                instr_pc_q    <= pc_in;
            end else if (redirect || (instr_valid_q && bus.instr_ready)) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = fetch_req;
    assign bus.imem_addr   = pc_in;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_data  = instr_data_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_control.sv
// Bench for pc_fetch_control: external PC register, latency-programmable memory,
// scoreboard of expected decode-side instructions plus a table of single-cycle vectors.
module tb_pc_fetch_control;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] pc_next;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;

    logic              pc_loop;
    logic [ADDR_W-1:0] pc_force;
    logic [ADDR_W-1:0] pc_reg;
    logic              ack_force;
    int                wait_n;
    int                wait_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              ack;
        logic              br;
        logic [ADDR_W-1:0] tgt;
        logic              exp_req;
        logic [ADDR_W-1:0] exp_next;
    } vec_t;
    vec_t vecs[6];

    pc_fetch_control_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    pc_fetch_control #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halt         (halt),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a, a};
    endfunction

    // External program_counter register
    always @(posedge clk) pc_reg <= pc_next;
    assign pc_in = pc_loop ? pc_reg : pc_force;

    // Read-only memory with wait_n cycles of ack latency
    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end
    always_comb begin
        bus.imem_ack   = ack_force || (bus.imem_req && (wait_cnt >= wait_n));
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] p);
        sb_q.push_back({p, mem_word(p)});
    endtask

    // Scoreboard: every decode handshake must match the next expected instruction
    always @(negedge clk) begin
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_instr: got pc %0h expected none at %0t", bus.instr_pc, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("instr_pc", 32'(bus.instr_pc), 32'(mon_e.pc));
                check("instr_data", 32'(bus.instr_data), 32'(mon_e.data));
            end
        end
    end

    // Branch out of HALTED to start, stream n instructions, then halt again.
    task automatic run_from(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] p;
        for (int k = 0; k < n; k++) push(start + ADDR_W'(k));
        branch_valid  = 1'b1;
        branch_target = start;
        halt          = 1'b0;
        @(negedge clk);
        check("run_branch_next", 32'(pc_next), 32'(start));
        tick();
        branch_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            p = start + ADDR_W'(k);
            @(negedge clk);
            check("run_addr", 32'(bus.imem_addr), 32'(p));
            check("run_next", 32'(pc_next), 32'(ADDR_W'(p + 1)));
            tick();
        end
        halt = 1'b1;
        @(negedge clk);
        check("run_halt_noreq", 32'(bus.imem_req), 32'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; halt = 1'b0; branch_valid = 1'b0; branch_target = '0;
        bus.instr_ready = 1'b1; ack_force = 1'b0; wait_n = 0;
        pc_loop = 1'b1; pc_force = '0;

        //            pc     ack   br    tgt    req   next
        vecs[0] = '{8'h20, 1'b1, 1'b0, 8'h00, 1'b1, 8'h21};
        vecs[1] = '{8'h21, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{8'h30, 1'b1, 1'b1, 8'h80, 1'b0, 8'h80};
        vecs[4] = '{8'h31, 1'b0, 1'b1, 8'h07, 1'b0, 8'h07};
        vecs[5] = '{8'h7F, 1'b1, 1'b0, 8'h00, 1'b1, 8'h80};

        // Reset values
        tick(); tick();
        @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'(0));
        check("rst_next", 32'(pc_next), 32'(0));
        check("rst_valid", 32'(bus.instr_valid), 32'(0));
        check("rst_data", 32'(bus.instr_data), 32'(0));
        check("rst_pc", 32'(bus.instr_pc), 32'(0));

        // Stream from reset, zero-wait memory
        for (int k = 0; k < 8; k++) push(ADDR_W'(k));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_req", 32'(bus.imem_req), 32'(0));
        check("idle_next", 32'(pc_next), 32'(0));
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stream_req", 32'(bus.imem_req), 32'(1));
            check("stream_addr", 32'(bus.imem_addr), 32'(k));
            check("stream_next", 32'(pc_next), 32'(k + 1));
            if (k == 0) check("stream_valid0", 32'(bus.instr_valid), 32'(0));
            if (k == 1) check("stream_valid1", 32'(bus.instr_valid), 32'(1));
            tick();
        end
        halt = 1'b1;
        @(negedge clk);
        check("halt_noreq", 32'(bus.imem_req), 32'(0));
        tick();

        // Backpressure: slot full for 3 cycles
        bus.instr_ready = 1'b0;
        push(8'h08); push(8'h09);
        halt = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp_req_first", 32'(bus.imem_req), 32'(1));
        check("bp_addr_first", 32'(bus.imem_addr), 32'(8'h08));
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_held", 32'(bus.imem_req), 32'(0));
            check("bp_pc_held", 32'(bus.instr_pc), 32'(8'h08));
            check("bp_data_held", 32'(bus.instr_data), 32'(mem_word(8'h08)));
            check("bp_next_hold", 32'(pc_next), 32'(8'h09));
            tick();
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_req", 32'(bus.imem_req), 32'(1));
        check("bp_resume_addr", 32'(bus.imem_addr), 32'(8'h09));
        check("bp_resume_next", 32'(pc_next), 32'(8'h0A));
        tick();
        halt = 1'b1;
        @(negedge clk);
        tick();

        // Single-cycle vector table, PC driven directly
        halt = 1'b0; pc_loop = 1'b0; pc_force = vecs[0].pc; wait_n = 15;
        @(negedge clk);
        tick();
        for (int i = 0; i < 6; i++) begin
            pc_force      = vecs[i].pc;
            ack_force     = vecs[i].ack;
            branch_valid  = vecs[i].br;
            branch_target = vecs[i].tgt;
            if (vecs[i].exp_req && vecs[i].ack) push(vecs[i].pc);
            @(negedge clk);
            check("vec_req", 32'(bus.imem_req), 32'(vecs[i].exp_req));
            check("vec_next", 32'(pc_next), 32'(vecs[i].exp_next));
            tick();
        end
        ack_force = 1'b0; branch_valid = 1'b0; halt = 1'b1; pc_loop = 1'b1;
        @(negedge clk);
        tick();
        wait_n = 0;

        // Wrap 0xFE -> 0xFF -> 0x00
        run_from(8'hFE, 3);

        // Halt at 0x10 with 2-cycle ack latency
        wait_n = 2;
        push(8'h10);
        branch_valid = 1'b1; branch_target = 8'h10;
        @(negedge clk);
        tick();
        branch_valid = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("hl_req_f1", 32'(bus.imem_req), 32'(1));
        check("hl_ack_f1", 32'(bus.imem_ack), 32'(0));
        tick();
        halt = 1'b1;
        @(negedge clk);
        check("hl_pending_req", 32'(bus.imem_req), 32'(1));
        check("hl_pending_addr", 32'(bus.imem_addr), 32'(8'h10));
        tick();
        @(negedge clk);
        check("hl_ack_req", 32'(bus.imem_req), 32'(1));
        check("hl_ack_next", 32'(pc_next), 32'(8'h11));
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hl_noreq", 32'(bus.imem_req), 32'(0));
            check("hl_pc_hold", 32'(bus.imem_addr), 32'(8'h11));
            check("hl_next_hold", 32'(pc_next), 32'(8'h11));
            tick();
        end
        push(8'h11);
        halt = 1'b0;
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hl_rel_req", 32'(bus.imem_req), 32'(1));
            check("hl_rel_addr", 32'(bus.imem_addr), 32'(8'h11));
            check("hl_rel_next", 32'(pc_next), 32'((i == 2) ? 8'h12 : 8'h11));
            tick();
        end
        halt = 1'b1;
        @(negedge clk);
        check("hl_rel_stop", 32'(bus.imem_req), 32'(0));
        tick();
        wait_n = 0;

        // Branch to 0x40 while memory acks at 0x05
        push(8'h03); push(8'h04); push(8'h40); push(8'h41);
        branch_valid = 1'b1; branch_target = 8'h03; halt = 1'b0;
        @(negedge clk);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        branch_valid = 1'b1; branch_target = 8'h40; ack_force = 1'b1;
        @(negedge clk);
        check("br_addr_old", 32'(bus.imem_addr), 32'(8'h05));
        check("br_noreq", 32'(bus.imem_req), 32'(0));
        check("br_next", 32'(pc_next), 32'(8'h40));
        tick();
        branch_valid = 1'b0; ack_force = 1'b0;
        @(negedge clk);
        check("br_tgt_req", 32'(bus.imem_req), 32'(1));
        check("br_tgt_addr", 32'(bus.imem_addr), 32'(8'h40));
        tick();
        @(negedge clk);
        check("br_tgt1_addr", 32'(bus.imem_addr), 32'(8'h41));
        check("br_tgt1_next", 32'(pc_next), 32'(8'h42));
        tick();
        halt = 1'b1;
        @(negedge clk);
        tick();

        // Reset mid-stream
        push(8'h50); push(8'h51);
        branch_valid = 1'b1; branch_target = 8'h50; halt = 1'b0;
        @(negedge clk);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("mr_valid_before", 32'(bus.instr_valid), 32'(1));
        check("mr_req_before", 32'(bus.imem_req), 32'(1));
        tick();
        rst = 1'b1; halt = 1'b1;
        @(negedge clk);
        check("mr_req_in_rst", 32'(bus.imem_req), 32'(0));
        check("mr_next_in_rst", 32'(pc_next), 32'(0));
        tick();
        @(negedge clk);
        check("mr_valid_after", 32'(bus.instr_valid), 32'(0));
        check("mr_req_after", 32'(bus.imem_req), 32'(0));
        check("mr_next_after", 32'(pc_next), 32'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_post_valid", 32'(bus.instr_valid), 32'(0));
            check("mr_post_req", 32'(bus.imem_req), 32'(0));
            check("mr_post_next", 32'(pc_next), 32'(0));
            tick();
        end

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
